alu_arbiter_ctrl: RTL and testbench

- Shares the single 16-bit ALU between two requesters: port 0 is the execute path, port 1 is the auxiliary/address path.
- Arbitrates between them round-robin and latches the granted operands into the ALU.
- Captures the ALU result into a response register with a valid/ready handshake.
- Owns the architectural Z/N/V flag register and updates it with the per-opcode flag mask.

---
 rtl/alu_arbiter_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_alu_arbiter_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_ctrl
// Purpose  : Shares one 16-bit ALU between two requesters (0 = execute path,
//            1 = auxiliary/address path). Round-robin arbitration, operand
//            latching, response register with valid/ready handshake, and the
//            architectural Z/N/V flag register with per-opcode write masks.
// Ports    : clk, rst                     - clock, synchronous active-high reset
//            req{0,1}_valid/_ready        - requester handshake (ready is comb.)
//            req{0,1}_a/_b/_imm/_op       - requester operands and opcode
//            alu_a/_b/_imm/_op            - operand register driving the ALU
//            alu_out, alu_z/_n/_v         - ALU result and flag outputs
//            rsp_valid/_ready/_id/_data/_err - response channel
//            flag_z/_n/_v                 - architectural flags
// Options  : `define FLAG_FWD_EN makes flag_* show the post-EXEC flag values
//            while in EXEC; register contents are the same in both builds.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter_ctrl #(
  parameter logic       RESET_PRIO = 1'b0,
  parameter logic [2:0] FLAG_RESET = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [3:0]  req0_imm,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [3:0]  req1_imm,
  input  logic [3:0]  req1_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_imm,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_out,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        alu_v,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_v
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_EXEC = 2'd1;
  localparam logic [1:0] c_HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        prio_q, prio_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic [3:0]  opimm_q, opimm_d;
  logic [3:0]  opop_q, opop_d;
  logic        opid_q, opid_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic [2:0]  flags_q, flags_d;      // {Z,N,V}

  logic        w_idle;
  logic        w_grant0;
  logic        w_grant1;
  logic [2:0]  w_mask;
  logic [2:0]  w_flags_exec;
  logic [2:0]  w_flags_out;

  // Which of {Z,N,V} an opcode is allowed to write. Invalid opcodes
  // (>= 4'b1010) fall into the default and leave every flag untouched.
  function automatic logic [2:0] flag_mask(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001:                     flag_mask = 3'b111;
      4'b0010, 4'b0100, 4'b0101, 4'b0110:   flag_mask = 3'b100;
      default:                              flag_mask = 3'b000;
    endcase
  endfunction

  // A lone requester always wins; on contention prio_q picks the winner.
  assign w_idle     = (state_q == c_IDLE);
  assign w_grant0   = req0_valid & (~req1_valid | ~prio_q);
  assign w_grant1   = req1_valid & (~req0_valid |  prio_q);
  assign req0_ready = w_idle & w_grant0;
  assign req1_ready = w_idle & w_grant1;

  // Flag value that will be registered at the end of EXEC: masked ALU flags
  // merged with the bits the opcode does not own.
  assign w_mask       = flag_mask(opop_q);
  assign w_flags_exec = (w_mask & {alu_z, alu_n, alu_v}) | (~w_mask & flags_q);

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    opimm_d     = opimm_q;
    opop_d      = opop_q;
    opid_d      = opid_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    flags_d     = flags_q;
    case (state_q)
      c_IDLE: begin
        if (w_grant0 | w_grant1) begin
          opid_d  = w_grant1;
          opa_d   = w_grant1 ? req1_a   : req0_a;
          opb_d   = w_grant1 ? req1_b   : req0_b;
          opimm_d = w_grant1 ? req1_imm : req0_imm;
          opop_d  = w_grant1 ? req1_op  : req0_op;
          prio_d  = ~w_grant1;
          state_d = c_EXEC;
        end
      end
      c_EXEC: begin
        rsp_data_d  = alu_out;
        rsp_id_d    = opid_q;
        rsp_err_d   = (opop_q >= 4'b1010);
        rsp_valid_d = 1'b1;
        flags_d     = w_flags_exec;
        state_d     = c_HOLD;
      end
      c_HOLD: begin
        // Returning to IDLE only after the handshake edge guarantees no new
        // accept can coincide with the response being taken.
        if (rsp_valid_q & rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = c_IDLE;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= c_IDLE;
      prio_q      <= RESET_PRIO;
      opa_q       <= 16'h0000;
      opb_q       <= 16'h0000;
      opimm_q     <= 4'h0;
      opop_q      <= 4'h0;
      opid_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 16'h0000;
      rsp_err_q   <= 1'b0;
      flags_q     <= FLAG_RESET;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      opimm_q     <= opimm_d;
      opop_q      <= opop_d;
      opid_q      <= opid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      flags_q     <= flags_d;
    end
  end

  // The ALU always sees the operand register, whatever the state.
  assign alu_a   = opa_q;
  assign alu_b   = opb_q;
  assign alu_imm = opimm_q;
  assign alu_op  = opop_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

`ifdef FLAG_FWD_EN
  assign w_flags_out = (state_q == c_EXEC) ? w_flags_exec : flags_q;
`else
  assign w_flags_out = flags_q;
`endif

  assign {flag_z, flag_n, flag_v} = w_flags_out;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter_ctrl
// Purpose  : Self-checking bench for alu_arbiter_ctrl. Provides a stand-in
//            ALU and a transaction-level reference model (priority bit, flag
//            register, opcode flag-mask table) that predicts every response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter_ctrl;

  localparam logic       c_RESET_PRIO = 1'b0;
  localparam logic [2:0] c_FLAG_RESET = 3'b000;

  logic        clk, rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_imm, req0_op, req1_imm, req1_op;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_imm, alu_op;
  logic        alu_z, alu_n, alu_v;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [15:0] rsp_data;
  logic        flag_z, flag_n, flag_v;

  int n_checks = 0;
  int n_pass   = 0;

  alu_arbiter_ctrl #(.RESET_PRIO(c_RESET_PRIO), .FLAG_RESET(c_FLAG_RESET)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_imm(req0_imm), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_imm(req1_imm), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm), .alu_op(alu_op),
    .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: returns {result, Z, N, V}. Non-arithmetic ops still produce
  // a V bit so that a wrong flag mask becomes visible.
  function automatic logic [18:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [3:0] imm);
    logic [15:0] s;
    logic        v;
    v = a[0] ^ b[1];
    case (op)
      4'd0: begin s = a + b; v = (a[15] == b[15]) && (s[15] != a[15]); end
      4'd1: begin s = a - b; v = (a[15] != b[15]) && (s[15] != a[15]); end
      4'd2: s = a & b;
      4'd3: s = a | b;
      4'd4: s = a ^ b;
      4'd5: s = a << imm;
      4'd6: s = a >> imm;
      4'd7: s = ~a;
      4'd8: s = a + 16'd1;
      4'd9: s = b;
      default: s = 16'hDEAD;
    endcase
    return {s, (s == 16'h0000), s[15], v};
  endfunction

  logic [18:0] w_alu_res;
  assign w_alu_res = alu_fn(alu_op, alu_a, alu_b, alu_imm);
  assign alu_out   = w_alu_res[18:3];
  assign {alu_z, alu_n, alu_v} = w_alu_res[2:0];

  // ---------------- reference model ----------------
  logic       m_prio;
  logic [2:0] m_flags;

  function automatic logic [2:0] flag_mask(input logic [3:0] op);
    case (op)
      4'd0, 4'd1:             return 3'b111;
      4'd2, 4'd4, 4'd5, 4'd6: return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  task automatic m_pick(input bit v0, input bit v1, output logic id);
    id     = (v0 && v1) ? m_prio : logic'(v1);
    m_prio = ~id;
  endtask

  task automatic m_exec(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] imm, output logic [15:0] d, output logic e);
    logic [18:0] r;
    logic [2:0]  mk;
    r  = alu_fn(op, a, b, imm);
    mk = flag_mask(op);
    d  = r[18:3];
    e  = (op > 4'd9);
    for (int i = 0; i < 3; i++) if (mk[i]) m_flags[i] = r[i];
  endtask

  // ---------------- transaction driver (observes, does not judge) ----------
  bit          o_to, o_r0, o_r1, o_stable, o_busy;
  logic        o_ev, o_rv, o_rid, o_rerr, o_after_v;
  logic [15:0] o_rdata;
  logic [2:0]  o_fexec, o_fhold;
  logic [39:0] o_alu;

  // Entered at posedge+1 with requests driven; leaves at posedge+1 in IDLE.
  task automatic serve(input int hold);
    int n;
    n = 0; o_to = 0; o_stable = 1; o_busy = 0;
    #1;
    while (!(req0_ready || req1_ready) && n < 8) begin
      @(posedge clk); #2; n++;
    end
    if (!(req0_ready || req1_ready)) begin o_to = 1; return; end
    o_r0 = req0_ready; o_r1 = req1_ready;
    @(posedge clk); #1;
    if (o_r0) req0_valid = 1'b0;
    if (o_r1) req1_valid = 1'b0;
    rsp_ready = (hold == 0);
    #1;
    o_fexec = {flag_z, flag_n, flag_v};
    o_ev    = rsp_valid;
    o_alu   = {alu_a, alu_b, alu_imm, alu_op};
    @(posedge clk); #2;
    o_rv = rsp_valid; o_rid = rsp_id; o_rdata = rsp_data; o_rerr = rsp_err;
    o_fhold = {flag_z, flag_n, flag_v};
    o_busy  = req0_ready | req1_ready;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #2;
      if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {o_rv, o_rid, o_rdata, o_rerr}) o_stable = 0;
      o_busy |= req0_ready | req1_ready;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    o_after_v = rsp_valid;
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1; rsp_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_prio = c_RESET_PRIO; m_flags = c_FLAG_RESET;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    do_reset();
    #1;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if ({rsp_id, rsp_err} !== 2'b00) $display("FAIL reset_id_err: got %b want 00", {rsp_id, rsp_err}); else n_pass++;
    n_checks++; if (rsp_data !== 16'h0000) $display("FAIL reset_rsp_data: got %h want 0000", rsp_data); else n_pass++;
    n_checks++; if ({flag_z, flag_n, flag_v} !== c_FLAG_RESET) $display("FAIL reset_flags: got %b want %b", {flag_z, flag_n, flag_v}, c_FLAG_RESET); else n_pass++;
    n_checks++; if ({alu_a, alu_b, alu_imm, alu_op} !== 40'h0) $display("FAIL reset_alu: got %h want 0", {alu_a, alu_b, alu_imm, alu_op}); else n_pass++;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_add_overflow;
    logic id, e; logic [15:0] d;
    req0_a = 16'h7FFF; req0_b = 16'h0001; req0_imm = 4'h0; req0_op = 4'd0; req0_valid = 1'b1;
    m_pick(1, 0, id); m_exec(4'd0, 16'h7FFF, 16'h0001, 4'h0, d, e);
    serve(0);
    n_checks++; if (o_to !== 1'b0) $display("FAIL add_timeout: got %b want 0", o_to); else n_pass++;
    n_checks++; if (o_ev !== 1'b0) $display("FAIL add_valid_in_exec: got %b want 0", o_ev); else n_pass++;
    n_checks++; if ({o_rv, o_rid, o_rdata} !== {1'b1, 1'b0, 16'h8000}) $display("FAIL add_rsp: got %b/%b/%h want 1/0/8000", o_rv, o_rid, o_rdata); else n_pass++;
    n_checks++; if (o_fhold !== 3'b011) $display("FAIL add_flags: got %b want 011", o_fhold); else n_pass++;
  endtask

  task automatic test_flag_z_only;
    logic id, e; logic [15:0] d;
    req1_a = 16'h00FF; req1_b = 16'h00FF; req1_imm = 4'h0; req1_op = 4'd4; req1_valid = 1'b1;
    m_pick(0, 1, id); m_exec(4'd4, 16'h00FF, 16'h00FF, 4'h0, d, e);
    serve(0);
    n_checks++; if ({o_to, o_rid, o_rdata} !== {1'b0, 1'b1, 16'h0000}) $display("FAIL xor_rsp: got to=%b id=%b data=%h want 0/1/0000", o_to, o_rid, o_rdata); else n_pass++;
    n_checks++; if (o_fhold !== 3'b111) $display("FAIL xor_flags: got %b want 111", o_fhold); else n_pass++;
  endtask

  task automatic test_arbitration;
    logic id, e; logic [15:0] d;
    do_reset();
    req0_a = 16'd5; req0_b = 16'd5; req0_imm = 4'h0; req0_op = 4'd1; req0_valid = 1'b1;
    req1_a = 16'h0001; req1_b = 16'h0000; req1_imm = 4'd4; req1_op = 4'd5; req1_valid = 1'b1;
    m_pick(1, 1, id); m_exec(4'd1, 16'd5, 16'd5, 4'h0, d, e);
    serve(0);
    n_checks++; if ({o_r1, o_r0} !== 2'b01) $display("FAIL arb_first_ready: got %b want 01", {o_r1, o_r0}); else n_pass++;
    n_checks++; if ({o_rid, o_rdata, o_fhold} !== {1'b0, 16'h0000, 3'b100}) $display("FAIL arb_first_rsp: got %b/%h/%b want 0/0000/100", o_rid, o_rdata, o_fhold); else n_pass++;
    m_pick(0, 1, id); m_exec(4'd5, 16'h0001, 16'h0000, 4'd4, d, e);
    serve(0);
    n_checks++; if ({o_to, o_rid, o_rdata, o_fhold} !== {1'b0, 1'b1, 16'h0010, 3'b000}) $display("FAIL arb_second_rsp: got %b/%b/%h/%b want 0/1/0010/000", o_to, o_rid, o_rdata, o_fhold); else n_pass++;
  endtask

  task automatic test_backpressure;
    logic id, e; logic [15:0] d;
    req0_a = 16'h1234; req0_b = 16'h1111; req0_imm = 4'h0; req0_op = 4'd0; req0_valid = 1'b1;
    req1_a = 16'hF0F0; req1_b = 16'h0FF0; req1_imm = 4'h0; req1_op = 4'd2; req1_valid = 1'b1;
    m_pick(1, 1, id); m_exec(4'd0, 16'h1234, 16'h1111, 4'h0, d, e);
    serve(5);
    n_checks++; if ({o_rid, o_rdata} !== {id, d}) $display("FAIL bp_rsp: got %b/%h want %b/%h", o_rid, o_rdata, id, d); else n_pass++;
    n_checks++; if (o_stable !== 1'b1) $display("FAIL bp_stable: got %b want 1", o_stable); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL bp_ready_in_hold: got %b want 0", o_busy); else n_pass++;
    n_checks++; if (o_after_v !== 1'b0) $display("FAIL bp_single_handshake: got %b want 0", o_after_v); else n_pass++;
    m_pick(0, 1, id); m_exec(4'd2, 16'hF0F0, 16'h0FF0, 4'h0, d, e);
    serve(0);
    n_checks++; if ({o_to, o_rid, o_rdata} !== {1'b0, 1'b1, 16'h00F0}) $display("FAIL bp_next_grant: got %b/%b/%h want 0/1/00f0", o_to, o_rid, o_rdata); else n_pass++;
  endtask

  task automatic test_invalid_op;
    logic id, e; logic [15:0] d; logic [2:0] fold;
    fold = m_flags;
    req0_a = 16'h0000; req0_b = 16'h0000; req0_imm = 4'h0; req0_op = 4'b1100; req0_valid = 1'b1;
    m_pick(1, 0, id); m_exec(4'b1100, 16'h0000, 16'h0000, 4'h0, d, e);
    serve(0);
    n_checks++; if ({o_to, o_rerr} !== 2'b01) $display("FAIL inv_err: got to=%b err=%b want 0/1", o_to, o_rerr); else n_pass++;
    n_checks++; if (o_fhold !== fold) $display("FAIL inv_flags: got %b want %b", o_fhold, fold); else n_pass++;
    req0_a = 16'h8000; req0_b = 16'h8000; req0_op = 4'd0; req0_valid = 1'b1;
    m_pick(1, 0, id); m_exec(4'd0, 16'h8000, 16'h8000, 4'h0, d, e);
    serve(0);
    n_checks++; if ({o_rerr, o_fhold, o_rdata} !== {1'b0, m_flags, d}) $display("FAIL inv_next_ok: got %b/%b/%h want 0/%b/%h", o_rerr, o_fhold, o_rdata, m_flags, d); else n_pass++;
  endtask

  task automatic test_reset_exec;
    logic id, e; logic [15:0] d;
    bit seen;
    req0_a = 16'hFFFF; req0_b = 16'h0001; req0_imm = 4'h0; req0_op = 4'd0; req0_valid = 1'b1;
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req0_ready !== 1'b1) $display("FAIL rx_accept: got %b want 1", req0_ready); else n_pass++;
    @(posedge clk); #1;
    req0_valid = 1'b0;
`ifdef FLAG_FWD_EN
    #1;
    n_checks++; if (flag_z !== 1'b1) $display("FAIL rx_fwd_z: got %b want 1", flag_z); else n_pass++;
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_prio = c_RESET_PRIO; m_flags = c_FLAG_RESET;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rx_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if ({flag_z, flag_n, flag_v} !== c_FLAG_RESET) $display("FAIL rx_flags: got %b want %b", {flag_z, flag_n, flag_v}, c_FLAG_RESET); else n_pass++;
    seen = 0;
    repeat (4) begin @(posedge clk); #1; if (rsp_valid) seen = 1; end
    n_checks++; if (seen !== 1'b0) $display("FAIL rx_no_response: got %b want 0", seen); else n_pass++;
    rsp_ready = 1'b0;
    req1_a = 16'h0001; req1_b = 16'h0001; req1_imm = 4'h0; req1_op = 4'd0; req1_valid = 1'b1;
    m_pick(0, 1, id); m_exec(4'd0, 16'h0001, 16'h0001, 4'h0, d, e);
    serve(0);
    n_checks++; if ({o_to, o_rid, o_rdata} !== {1'b0, 1'b1, 16'h0002}) $display("FAIL rx_idle_after: got %b/%b/%h want 0/1/0002", o_to, o_rid, o_rdata); else n_pass++;
  endtask

  task automatic test_random;
    logic [15:0] pa [2];
    logic [15:0] pb [2];
    logic [3:0]  pi [2];
    logic [3:0]  po [2];
    bit          pend [2];
    logic        id, e;
    logic [15:0] d;
    logic [2:0]  fold, fx;
    pend[0] = 0; pend[1] = 0;
    for (int t = 0; t < 50; t++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && ($urandom_range(0, 2) != 0 || (r == 1 && !pend[0]))) begin
          pend[r] = 1;
          pa[r] = 16'($urandom); pb[r] = 16'($urandom);
          pi[r] = 4'($urandom);  po[r] = 4'($urandom_range(0, 11));
          if ($urandom_range(0, 3) == 0) pb[r] = pa[r];
        end
      end
      req0_valid = pend[0]; req0_a = pa[0]; req0_b = pb[0]; req0_imm = pi[0]; req0_op = po[0];
      req1_valid = pend[1]; req1_a = pa[1]; req1_b = pb[1]; req1_imm = pi[1]; req1_op = po[1];
      m_pick(pend[0], pend[1], id);
      fold = m_flags;
      m_exec(po[id], pa[id], pb[id], pi[id], d, e);
`ifdef FLAG_FWD_EN
      fx = m_flags;
`else
      fx = fold;
`endif
      serve($urandom_range(0, 3));
      pend[id] = 0;
      n_checks++; if (o_to !== 1'b0) $display("FAIL rnd_timeout t=%0d: got %b want 0", t, o_to); else n_pass++;
      n_checks++; if ({o_r1, o_r0} !== (id ? 2'b10 : 2'b01)) $display("FAIL rnd_ready t=%0d: got %b want id %b", t, {o_r1, o_r0}, id); else n_pass++;
      n_checks++; if (o_alu !== {pa[id], pb[id], pi[id], po[id]}) $display("FAIL rnd_alu_in t=%0d: got %h want %h", t, o_alu, {pa[id], pb[id], pi[id], po[id]}); else n_pass++;
      n_checks++; if ({o_ev, o_rv} !== 2'b01) $display("FAIL rnd_latency t=%0d: got %b want 01", t, {o_ev, o_rv}); else n_pass++;
      n_checks++; if ({o_rid, o_rdata, o_rerr} !== {id, d, e}) $display("FAIL rnd_rsp t=%0d: got %b/%h/%b want %b/%h/%b", t, o_rid, o_rdata, o_rerr, id, d, e); else n_pass++;
      n_checks++; if (o_fhold !== m_flags) $display("FAIL rnd_flags t=%0d: got %b want %b", t, o_fhold, m_flags); else n_pass++;
      n_checks++; if (o_fexec !== fx) $display("FAIL rnd_exec_flags t=%0d: got %b want %b", t, o_fexec, fx); else n_pass++;
      n_checks++; if ({o_stable, o_busy, o_after_v} !== 3'b100) $display("FAIL rnd_hold t=%0d: got %b want 100", t, {o_stable, o_busy, o_after_v}); else n_pass++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_imm = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_imm = '0; req1_op = '0;
    m_prio = c_RESET_PRIO; m_flags = c_FLAG_RESET;
    test_reset();
    test_add_overflow();
    test_flag_z_only();
    test_arbitration();
    test_backpressure();
    test_invalid_op();
    test_reset_exec();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
